// File: rtl/mrc_pkg.sv
// rtl/mrc_pkg.sv - shared defaults for the multi-rate counter
package mrc_pkg;

  localparam int unsigned DEF_CNT_W = 4;
  localparam int unsigned DEF_DIV_W = 28;

  localparam int unsigned DEF_DIV0 = 1;
  localparam int unsigned DEF_DIV1 = 5000000;
  localparam int unsigned DEF_DIV2 = 50000000;
  localparam int unsigned DEF_DIV3 = 100000000;

endpackage

// File: rtl/rate_tick_gen.sv
// rtl/rate_tick_gen.sv - selectable-period divider producing the internal tick
module rate_tick_gen
  import mrc_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W,
  parameter int unsigned DIV0  = DEF_DIV0,
  parameter int unsigned DIV1  = DEF_DIV1,
  parameter int unsigned DIV2  = DEF_DIV2,
  parameter int unsigned DIV3  = DEF_DIV3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] select,
  input  logic       restart,
  output logic       tick_o
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       sel_q, sel_d;

  // Period minus one for a given rate select; the count runs reload..0 inclusive.
  function automatic logic [DIV_W-1:0] reload_val(input logic [1:0] s);
    logic [DIV_W-1:0] r;
    case (s)
      2'd0:    r = DIV_W'(DIV0 - 32'd1);
      2'd1:    r = DIV_W'(DIV1 - 32'd1);
      2'd2:    r = DIV_W'(DIV2 - 32'd1);
      default: r = DIV_W'(DIV3 - 32'd1);
    endcase
    return r;
  endfunction

  // Next-state: a rate change restarts the period and wins over everything,
  // then an external restart, then the enabled count-down with tick at zero.
  always_comb begin
    div_cnt_d = div_cnt_q;
    sel_d     = sel_q;
    tick_o    = 1'b0;
    if (select != sel_q) begin
      sel_d     = select;
      div_cnt_d = reload_val(select);
    end else if (restart) begin
      div_cnt_d = reload_val(sel_q);
    end else if (enable) begin
      if (div_cnt_q == '0) begin
        tick_o    = 1'b1;
        div_cnt_d = reload_val(sel_q);
      end else begin
        div_cnt_d = div_cnt_q - 1'b1;
      end
    end
  end

  // Divider state register; reset leaves the count at zero so select 0 ticks at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      sel_q     <= 2'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sel_q     <= sel_d;
    end
  end

endmodule

// File: rtl/multi_rate_counter.sv
// rtl/multi_rate_counter.sv - up/down modulus counter advanced by a selectable-rate tick
module multi_rate_counter
  import mrc_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned DIV_W = DEF_DIV_W,
  parameter int unsigned DIV0  = DEF_DIV0,
  parameter int unsigned DIV1  = DEF_DIV1,
  parameter int unsigned DIV2  = DEF_DIV2,
  parameter int unsigned DIV3  = DEF_DIV3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       select,
  input  logic             par_load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             up_down,
  input  logic [CNT_W-1:0] modulus,
  output logic [CNT_W-1:0] q,
  output logic             tick,
  output logic             wrap
);

  logic             int_tick;
  logic [CNT_W-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  rate_tick_gen #(
    .DIV_W (DIV_W),
    .DIV0  (DIV0),
    .DIV1  (DIV1),
    .DIV2  (DIV2),
    .DIV3  (DIV3)
  ) u_rate_tick_gen (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .select  (select),
    .restart (par_load),
    .tick_o  (int_tick)
  );

  // Counter next-state: load beats tick beats hold; out-of-range values wrap on the next tick.
  always_comb begin
    q_d    = q_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (par_load) begin
      q_d = load_val;
    end else if (int_tick) begin
      tick_d = 1'b1;
      if (up_down) begin
        if (q_q >= modulus) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if ((q_q == '0) || (q_q > modulus)) begin
          q_d    = modulus;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  // Counter and pulse registers update together so pulses line up with the new q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: doc/multi_rate_counter.md
MULTI_RATE_COUNTER -- requirements
Module: multi_rate_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, setting the display-counter width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter DIV_W, default 28, setting the divider width in bits.
REQ-003 The block SHALL have parameters DIV0, DIV1, DIV2, DIV3, defaults 1, 5000000, 50000000, 100000000, each giving the tick period in clock cycles for select 0..3 (each 1..2^DIV_W).
REQ-004 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port enable, input, 1: 1 = divider and counter run; 0 = both hold.
REQ-007 Port select, input, 2: rate select, indexing DIV0..DIV3.
REQ-008 Port par_load, input, 1: synchronous load of load_val into q.
REQ-009 Port load_val, input, CNT_W: parallel-load value.
REQ-010 Port up_down, input, 1: 1 = count up, 0 = count down.
REQ-011 Port modulus, input, CNT_W: terminal count; q cycles over 0..modulus inclusive.
REQ-012 Port q, output, CNT_W: counter value, registered.
REQ-013 Port tick, output, 1: registered one-cycle pulse, high in the cycle q shows a tick-driven update.
REQ-014 Port wrap, output, 1: registered one-cycle pulse, high in the cycle q shows a wrap-around.

Function
REQ-015 The divider SHALL hold div_cnt (DIV_W bits) and sel_q (2 bits, the last select sampled).
REQ-016 If select != sel_q, the divider SHALL load div_cnt = DIV[select]-1 and update sel_q, with no internal tick that cycle, regardless of enable.
REQ-017 Otherwise, if enable=1 and div_cnt=0, an internal tick SHALL occur and div_cnt SHALL reload DIV[sel_q]-1.
REQ-018 Otherwise, if enable=1, div_cnt SHALL decrement by 1; if enable=0, div_cnt SHALL hold.
REQ-019 Consequence: with DIVn=1 the block ticks on every enabled cycle; with DIVn=N it ticks once per N enabled cycles.
REQ-020 Counter priority SHALL be: par_load > internal tick > hold.
REQ-021 par_load=1 SHALL set q=load_val and div_cnt=DIV[sel_q]-1; tick and wrap stay 0.
REQ-022 On a tick with up_down=1: if q >= modulus, q SHALL become 0 and wrap SHALL pulse; otherwise q SHALL become q+1.
REQ-023 On a tick with up_down=0: if q = 0 or q > modulus, q SHALL become modulus and wrap SHALL pulse; otherwise q SHALL become q-1.
REQ-024 load_val > modulus SHALL be loaded unchanged; the next tick then wraps per REQ-022/023.
REQ-025 modulus = 0 SHALL hold q at 0 with wrap pulsing on every tick.
REQ-026 A change to modulus or up_down SHALL take effect on the next tick, with no other side effect.
REQ-027 tick and wrap SHALL be registered and coincide with the clock edge that updates q, giving zero cycles of latency between the q update and the pulse.
REQ-028 Arithmetic SHALL be unsigned modulo 2^CNT_W, with no overflow outside the rules above.

Reset
REQ-029 On reset=1, regardless of clock, the block SHALL set q=0, tick=0, wrap=0, div_cnt=0, sel_q=0.
REQ-030 After reset is released with select=0 and enable=1, the first tick SHALL occur on the first rising edge.
REQ-031 Reset asserted mid-count SHALL abort any pending tick; no pulse may appear in the cycle reset is released.

Structure
REQ-032 The shared package mrc_pkg SHALL hold the default DIV0..DIV3 constants and the default DIV_W and CNT_W values.
REQ-033 The divider (REQ-015..018) SHALL be the single sub-module rate_tick_gen, with ports clock, reset, enable, select, restart and tick_o.
REQ-034 The top level SHALL contain the counter and pulse registers only.

Verification (bench overrides DIV0=1, DIV1=4, DIV2=8, DIV3=16, CNT_W=4)
REQ-035 Scenario: reset, then select=1, enable=1, up, modulus=15 -> tick every 4 cycles; q sequence 0,1,2,3.
REQ-036 Scenario: select=0, up, modulus=9, q=8 -> q goes 9, 0, with wrap high exactly in the cycle q=0.
REQ-037 Scenario: up_down=0, modulus=5, q=0, select=0 -> q goes 5, 4, with wrap high in the cycle q=5.
REQ-038 Scenario: par_load=1 with load_val=12 and modulus=9, coinciding with a tick -> q=12, no pulse; next tick gives q=0 with wrap.
REQ-039 Scenario: select changes 1->3 mid-period -> no tick for exactly 16 enabled cycles, then tick; with enable=0 for 5 cycles -> q and the tick phase are frozen.
REQ-040 Scenario: reset asserted asynchronously between edges at q=7 -> q=0 immediately, no tick or wrap while reset is high or in the release cycle.
